// File: rtl/full_connect3_argmax.sv
// Output layer (FC3) with argmax: scores NUM_CLASS classes against FC2 activations via the shared MultAdder/ROM.
// Optional macro OUT_SCORES_EN exposes every biased class score on oScores.
module full_connect3_argmax #(
    parameter logic [10:0] ROM_ADDR_BASE  = 11'h482,
    parameter logic [10:0] BIAS_ADDR_BASE = 11'h48C,
    parameter int          NUM_CLASS      = 10,
    parameter int          ROM_LAT        = 2
) (
    input  logic            clk,
    input  logic            iRst_n,
    input  logic            ena,
    input  logic [2047:0]   data_from_rom,
    input  logic [2047:0]   data_from_ram,
    input  logic [30:0]     data_from_MultAdder,
    output logic            done,
    output wire  [10:0]     addr_to_rom,
    output wire  [2047:0]   opr1_to_MultAdder,
    output wire  [2047:0]   opr2_to_MultAdder,
    output logic [3:0]      oDigit,
    output logic [30:0]     oScore
`ifdef OUT_SCORES_EN
    ,
    output logic [NUM_CLASS*31-1:0] oScores
`endif
);

    typedef enum logic [3:0] {
        BIAS_REQ,
        BIAS_WAIT,
        BIAS_GET,
        ROW_REQ,
        ROW_WAIT,
        ROW_GET,
        MAC_GET,
        CMP,
        DONE
    } state_t;

    state_t                  state;
    logic                    bus_en;
    logic [10:0]             addr_q;
    logic [2047:0]           opr1_q;
    logic [2047:0]           opr2_q;
    logic [NUM_CLASS*16-1:0] bias_q;
    logic [4:0]              k;
    logic [7:0]              wait_cnt;
    logic [30:0]             mac_q;
    logic [30:0]             max_q;
    logic [3:0]              max_idx;
    logic                    max_valid;

    logic [15:0]             cur_bias;
    logic [30:0]             score;
    logic [4:0]              k_next;

    // Shared buses are only driven while this stage owns them.
    assign addr_to_rom       = bus_en ? addr_q : 'z;
    assign opr1_to_MultAdder = bus_en ? opr1_q : 'z;
    assign opr2_to_MultAdder = bus_en ? opr2_q : 'z;

    // Bias is Q5.10-aligned to the MAC result; the sum wraps at 31 bits.
    always_comb begin
        cur_bias = bias_q[k*16 +: 16];
        score    = mac_q + {{5{cur_bias[15]}}, cur_bias, 10'b0};
        k_next   = k + 5'd1;
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= BIAS_REQ;
            bus_en    <= 1'b0;
            addr_q    <= '0;
            opr1_q    <= '0;
            opr2_q    <= '0;
            bias_q    <= '0;
            k         <= '0;
            wait_cnt  <= '0;
            mac_q     <= '0;
            max_q     <= '0;
            max_idx   <= '0;
            max_valid <= 1'b0;
            done      <= 1'b0;
            oDigit    <= 4'hF;
            oScore    <= '0;
`ifdef OUT_SCORES_EN
            oScores   <= '0;
`endif
        end else if (!ena) begin
            done   <= 1'b0;
            bus_en <= 1'b0;
            state  <= BIAS_REQ;
        end else begin
            bus_en <= 1'b1;
            case (state)
                BIAS_REQ: begin
                    addr_q   <= BIAS_ADDR_BASE;
                    wait_cnt <= 8'(ROM_LAT - 2);
                    state    <= (ROM_LAT > 1) ? BIAS_WAIT : BIAS_GET;
                end
                BIAS_WAIT: begin
                    if (wait_cnt == 8'd0) state <= BIAS_GET;
                    else                  wait_cnt <= wait_cnt - 8'd1;
                end
                BIAS_GET: begin
                    bias_q    <= data_from_rom[NUM_CLASS*16-1:0];
                    k         <= '0;
                    max_valid <= 1'b0;
                    state     <= ROW_REQ;
                end
                ROW_REQ: begin
                    addr_q   <= ROM_ADDR_BASE + 11'(k);
                    wait_cnt <= 8'(ROM_LAT - 2);
                    state    <= (ROM_LAT > 1) ? ROW_WAIT : ROW_GET;
                end
                ROW_WAIT: begin
                    if (wait_cnt == 8'd0) state <= ROW_GET;
                    else                  wait_cnt <= wait_cnt - 8'd1;
                end
                ROW_GET: begin
                    opr1_q <= data_from_ram;
                    opr2_q <= data_from_rom;
                    state  <= MAC_GET;
                end
                MAC_GET: begin
                    mac_q <= data_from_MultAdder;
                    state <= CMP;
                end
                CMP: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (!max_valid || ($signed(score) > $signed(max_q))) begin
                        max_q     <= score;
                        max_idx   <= k[3:0];
                        max_valid <= 1'b1;
                    end
`ifdef OUT_SCORES_EN
                    oScores[k*31 +: 31] <= score;
`endif
                    k     <= k_next;
                    state <= (k_next < 5'(NUM_CLASS)) ? ROW_REQ : DONE;
                end
                DONE: begin
                    oDigit <= max_idx;
                    oScore <= max_q;
                    done   <= 1'b1;
                end
                default: state <= BIAS_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_full_connect3_argmax.sv
// Directed testbench for full_connect3_argmax with ROM, RAM and MultAdder models.
// Compile with OUT_SCORES_EN defined to also check the per-class score outputs.
module tb_full_connect3_argmax;

    logic          clk = 1'b0;
    logic          iRst_n;
    logic          ena;
    logic [2047:0] data_from_rom;
    logic [2047:0] data_from_ram;
    logic [30:0]   data_from_MultAdder;
    logic          done;
    wire  [10:0]   addr_to_rom;
    wire  [2047:0] opr1_to_MultAdder;
    wire  [2047:0] opr2_to_MultAdder;
    logic [3:0]    oDigit;
    logic [30:0]   oScore;
`ifdef OUT_SCORES_EN
    logic [309:0]  oScores;
`endif

    logic [2047:0] rom_rows [0:9];
    logic [2047:0] bias_word;
    logic [30:0]   exp_scores [0:9];
    logic [3:0]    exp_digit;
    logic [30:0]   exp_score;
    int            check_count = 0;
    int            error_count = 0;
    int            edges;

    full_connect3_argmax dut (
        .clk                 (clk),
        .iRst_n              (iRst_n),
        .ena                 (ena),
        .data_from_rom       (data_from_rom),
        .data_from_ram       (data_from_ram),
        .data_from_MultAdder (data_from_MultAdder),
        .done                (done),
        .addr_to_rom         (addr_to_rom),
        .opr1_to_MultAdder   (opr1_to_MultAdder),
        .opr2_to_MultAdder   (opr2_to_MultAdder),
        .oDigit              (oDigit),
        .oScore              (oScore)
`ifdef OUT_SCORES_EN
        ,
        .oScores             (oScores)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] dot(input logic [2047:0] a, input logic [2047:0] w);
        logic signed [47:0] acc;
        logic signed [31:0] p;
        acc = '0;
        for (int i = 0; i < 128; i++) begin
            p   = $signed(a[i*16 +: 16]) * $signed(w[i*16 +: 16]);
            acc = acc + {{16{p[31]}}, p};
        end
        return acc[30:0];
    endfunction

    function automatic logic [2047:0] rom_read(input logic [10:0] a);
        int idx;
        idx = int'(a) - 'h482;
        if (idx >= 0 && idx <= 9) return rom_rows[idx];
        if (a == 11'h48C)         return bias_word;
        return '0;
    endfunction

    function automatic logic bus_released();
        logic a_rel, o1_rel, o2_rel;
        a_rel  = $isunknown(addr_to_rom) || (addr_to_rom == '0);
        o1_rel = $isunknown(opr1_to_MultAdder) || (opr1_to_MultAdder == '0);
        o2_rel = $isunknown(opr2_to_MultAdder) || (opr2_to_MultAdder == '0);
        return a_rel && o1_rel && o2_rel;
    endfunction

    // ROM with one register stage: data sampled ROM_LAT=2 edges after the address.
    always @(posedge clk) data_from_rom <= rom_read(addr_to_rom);

    always_comb data_from_MultAdder = dot(opr1_to_MultAdder, opr2_to_MultAdder);

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic compute_expected();
        logic [30:0]        mac, s;
        logic signed [31:0] sb;
        for (int c = 0; c < 10; c++) begin
            mac = dot(data_from_ram, rom_rows[c]);
            sb  = $signed(bias_word[c*16 +: 16]);
            s   = mac + 31'(sb * 1024);
            exp_scores[c] = s;
            if (c == 0 || $signed(s) > $signed(exp_score)) begin
                exp_score = s;
                exp_digit = 4'(c);
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic apply_stimulus(output int n);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        wait_done(n);
    endtask

    task automatic check_run(input string tag, input int n, input logic [3:0] d, input logic [30:0] s);
        check_output({tag, "_done"},  64'(done), 64'd1);
        check_output({tag, "_edges"}, 64'(n),    64'd54);
        check_output({tag, "_digit"}, 64'(oDigit), 64'(d));
        check_output({tag, "_score"}, 64'(oScore), 64'(s));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRst_n        = 1'b0;
        ena           = 1'b0;
        data_from_ram = '0;
        bias_word     = '0;
        for (int c = 0; c < 10; c++) rom_rows[c] = '0;
        #12;
        check_output("rst_done",  64'(done),   64'd0);
        check_output("rst_digit", 64'(oDigit), 64'hF);
        check_output("rst_score", 64'(oScore), 64'd0);
        check_output("rst_bus",   64'(bus_released()), 64'd1);
        @(negedge clk);
        iRst_n = 1'b1;

        // Single non-zero bias wins.
        bias_word[7*16 +: 16] = 16'h0100;
        apply_stimulus(edges);
        check_run("t1", edges, 4'd7, 31'h0040000);

        // Full tie goes to class 0.
        for (int c = 0; c < 10; c++) bias_word[c*16 +: 16] = 16'h0040;
        apply_stimulus(edges);
        check_run("t2", edges, 4'd0, 31'h0010000);

        // All-negative scores, tie between classes 0 and 3.
        for (int c = 0; c < 10; c++) bias_word[c*16 +: 16] = 16'(-(c + 1));
        bias_word[3*16 +: 16] = 16'hFFFF;
        apply_stimulus(edges);
        check_run("t3a", edges, 4'd0, 31'h7FFFFC00);
        bias_word[0*16 +: 16] = 16'hFFFE;
        apply_stimulus(edges);
        check_run("t3b", edges, 4'd3, 31'h7FFFFC00);

        // Random activations/weights, class 5 weights doubled.
        for (int i = 0; i < 128; i++) begin
            data_from_ram[i*16 +: 16] = 16'($urandom_range(0, 255)) - 16'd128;
            for (int c = 0; c < 10; c++)
                rom_rows[c][i*16 +: 16] = 16'($urandom_range(0, 127)) - 16'd64;
            rom_rows[5][i*16 +: 16] = rom_rows[5][i*16 +: 16] << 1;
        end
        for (int c = 0; c < 10; c++) bias_word[c*16 +: 16] = 16'($urandom_range(0, 511)) - 16'd256;
        compute_expected();
        apply_stimulus(edges);
        check_run("t4", edges, exp_digit, exp_score);

        // Abort at edge 20, then restart.
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        check_output("t5_bus_busy", 64'(bus_released()), 64'd0);
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        check_output("t5_abort_done",  64'(done),   64'd0);
        check_output("t5_abort_bus",   64'(bus_released()), 64'd1);
        check_output("t5_abort_digit", 64'(oDigit), 64'(exp_digit));
        check_output("t5_abort_score", 64'(oScore), 64'(exp_score));
        @(negedge clk);
        ena = 1'b1;
        wait_done(edges);
        check_run("t5", edges, exp_digit, exp_score);

        // Asynchronous reset while in a CMP cycle, then a clean run.
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (17) @(posedge clk);
        #2;
        iRst_n = 1'b0;
        #1;
        check_output("t6_rst_done",  64'(done),   64'd0);
        check_output("t6_rst_digit", 64'(oDigit), 64'hF);
        check_output("t6_rst_score", 64'(oScore), 64'd0);
        check_output("t6_rst_bus",   64'(bus_released()), 64'd1);
        #1;
        iRst_n = 1'b1;
        wait_done(edges);
        check_run("t6", edges, exp_digit, exp_score);
`ifdef OUT_SCORES_EN
        for (int c = 0; c < 10; c++)
            check_output($sformatf("t6_scores%0d", c), 64'(oScores[c*31 +: 31]), 64'(exp_scores[c]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
